// File: rtl/lamp_fpu_sqrt_ctrl.sv
// rtl/lamp_fpu_sqrt_ctrl.sv - round-robin front end sharing one lampFPU sqrt datapath
//
// Purpose:
//   Accepts one square-root operation at a time from N_REQ requesters
//   (round-robin). It resolves special operands (NaN, negative, zero or
//   subnormal, +inf) locally. Normal operands go to the multi-cycle sqrt core
//   with a single doSqrt pulse, and the core's result is awaited with a
//   timeout. The packed result goes back through a valid/ready response
//   channel.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid_i / req_op_i            per-requester request, operand i at [i*W +: W]
//   req_ready_o                       one-hot grant, combinational, only in IDLE
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_id_o, rsp_res_o, rsp_flags_o  requester index, {s,e,f}, {inv,ovf,udf,timeout}
//   do_sqrt_o                         one-cycle start pulse to the datapath
//   signum_op_o, ext_exp_op_o,
//   ext_mant_op_o                     unpacked operand, held from ISSUE through WAIT
//   is_inf_op_o, is_zero_op_o         always 0 (specials never reach the core)
//   s_res_i, e_res_i, f_res_i,
//   valid_i, is_overflow_i,
//   is_underflow_i                    datapath result, valid_i single-cycle

module lamp_fpu_sqrt_ctrl #(
  parameter int E_DW    = 8,
  parameter int F_DW    = 7,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 32,
  localparam int W      = 1 + E_DW + F_DW,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*W-1:0] req_op_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [ID_W-1:0]    rsp_id_o,
  output logic [W-1:0]       rsp_res_o,
  output logic [3:0]         rsp_flags_o,
  output logic               do_sqrt_o,
  output logic               signum_op_o,
  output logic [E_DW:0]      ext_exp_op_o,
  output logic [F_DW:0]      ext_mant_op_o,
  output logic               is_inf_op_o,
  output logic               is_zero_op_o,
  input  logic               s_res_i,
  input  logic [E_DW-1:0]    e_res_i,
  input  logic [F_DW-1:0]    f_res_i,
  input  logic               valid_i,
  input  logic               is_overflow_i,
  input  logic               is_underflow_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] wait_cnt;

  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W-1:0]  scan_id;
  logic [W-1:0]     op_sel;

  logic             op_s;
  logic [E_DW-1:0]  op_e;
  logic [F_DW-1:0]  op_f;
  logic             e_max;
  logic             e_zero;
  logic             f_zero;
  logic             special;
  logic             spec_inv;
  logic [W-1:0]     spec_res;

  // First valid requester at or after the round-robin pointer, scanning cyclically.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_id     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_id = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_found && req_valid_i[scan_id]) begin
        grant_found = 1'b1;
        grant_id    = scan_id;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state == S_IDLE && grant_found) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  always_comb begin
    op_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == grant_id) begin
        op_sel = req_op_i[k*W +: W];
      end
    end
  end

  assign op_s   = op_sel[W-1];
  assign op_e   = op_sel[W-2 -: E_DW];
  assign op_f   = op_sel[F_DW-1:0];
  assign e_max  = &op_e;
  assign e_zero = ~|op_e;
  assign f_zero = ~|op_f;

  // Classification is evaluated on the granted operand so specials can be
  // answered one cycle after the handshake. Priority order matters: a NaN
  // with the sign bit set is a quiet NaN, not an invalid operation, and a
  // negative zero/subnormal keeps its sign instead of raising invalid.
  always_comb begin
    special  = 1'b1;
    spec_inv = 1'b0;
    spec_res = '0;
    if (e_max && !f_zero) begin
      spec_res = QNAN;
    end else if (op_s && !e_zero) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (e_zero) begin
      spec_res = {op_s, {(W-1){1'b0}}};
    end else if (e_max) begin
      spec_res = op_sel;
    end else begin
      special = 1'b0;
    end
  end

  assign is_inf_op_o  = 1'b0;
  assign is_zero_op_o = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      wait_cnt      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_id_o      <= '0;
      rsp_res_o     <= '0;
      rsp_flags_o   <= '0;
      do_sqrt_o     <= 1'b0;
      signum_op_o   <= 1'b0;
      ext_exp_op_o  <= '0;
      ext_mant_op_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            rsp_id_o <= grant_id;
            if (special) begin
              rsp_res_o   <= spec_res;
              rsp_flags_o <= {spec_inv, 3'b000};
              rsp_valid_o <= 1'b1;
              state       <= S_RESP;
            end else begin
              do_sqrt_o     <= 1'b1;
              signum_op_o   <= op_s;
              ext_exp_op_o  <= {1'b0, op_e};
              ext_mant_op_o <= {1'b1, op_f};
              state         <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          do_sqrt_o <= 1'b0;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          // A result arriving on the last counted cycle beats the timeout.
          if (valid_i || wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            if (valid_i) begin
              rsp_res_o   <= {s_res_i, e_res_i, f_res_i};
              rsp_flags_o <= {1'b0, is_overflow_i, is_underflow_i, 1'b0};
            end else begin
              rsp_res_o   <= QNAN;
              rsp_flags_o <= 4'b0001;
            end
            rsp_valid_o   <= 1'b1;
            signum_op_o   <= 1'b0;
            ext_exp_op_o  <= '0;
            ext_mant_op_o <= '0;
            state         <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_res_o   <= '0;
            rsp_flags_o <= '0;
            rsp_id_o    <= '0;
            rr_ptr      <= (rsp_id_o == ID_W'(N_REQ - 1)) ? '0 : rsp_id_o + ID_W'(1);
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_fpu_sqrt_ctrl.sv
// tb/tb_lamp_fpu_sqrt_ctrl.sv - self-checking bench for lamp_fpu_sqrt_ctrl

module tb_lamp_fpu_sqrt_ctrl;

  localparam int E_DW    = 8;
  localparam int F_DW    = 7;
  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 32;
  localparam int W       = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] req_valid_i;
  logic [N_REQ*W-1:0] req_op_i;
  logic [N_REQ-1:0] req_ready_o;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [0:0]       rsp_id_o;
  logic [W-1:0]     rsp_res_o;
  logic [3:0]       rsp_flags_o;
  logic             do_sqrt_o;
  logic             signum_op_o;
  logic [E_DW:0]    ext_exp_op_o;
  logic [F_DW:0]    ext_mant_op_o;
  logic             is_inf_op_o;
  logic             is_zero_op_o;
  logic             s_res_i;
  logic [E_DW-1:0]  e_res_i;
  logic [F_DW-1:0]  f_res_i;
  logic             valid_i;
  logic             is_overflow_i;
  logic             is_underflow_i;

  logic             dp_valid = 1'b0;
  logic             late_valid = 1'b0;
  int               dp_delay = 0;
  logic [W-1:0]     dp_res = '0;
  logic             dp_ovf = 1'b0;
  logic             dp_udf = 1'b0;

  assign valid_i = dp_valid | late_valid;

  always #5 clk = ~clk;

  lamp_fpu_sqrt_ctrl #(
    .E_DW(E_DW), .F_DW(F_DW), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_res_o(rsp_res_o), .rsp_flags_o(rsp_flags_o),
    .do_sqrt_o(do_sqrt_o), .signum_op_o(signum_op_o),
    .ext_exp_op_o(ext_exp_op_o), .ext_mant_op_o(ext_mant_op_o),
    .is_inf_op_o(is_inf_op_o), .is_zero_op_o(is_zero_op_o),
    .s_res_i(s_res_i), .e_res_i(e_res_i), .f_res_i(f_res_i), .valid_i(valid_i),
    .is_overflow_i(is_overflow_i), .is_underflow_i(is_underflow_i)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Square-root front-end rules on a bfloat16 operand: 1 = answered without the core.
  function automatic bit model_special(input logic [15:0] op, output logic [15:0] res,
                                       output logic [3:0] fl);
    int e;
    int f;
    e = int'(op[14:7]);
    f = int'(op[6:0]);
    res = 16'h0000;
    fl  = 4'h0;
    if (e == 255 && f != 0) begin res = 16'h7FC0; return 1'b1; end
    if (op[15] && e != 0)   begin res = 16'h7FC0; fl = 4'b1000; return 1'b1; end
    if (e == 0)             begin res = op[15] ? 16'h8000 : 16'h0000; return 1'b1; end
    if (e == 255)           begin res = 16'h7F80; return 1'b1; end
    return 1'b0;
  endfunction

  // Datapath stand-in: answers each doSqrt after dp_delay cycles (0 = never).
  always begin
    @(posedge clk);
    #1;
    if (do_sqrt_o === 1'b1 && dp_delay > 0 && !rst) begin
      repeat (dp_delay) tick();
      {s_res_i, e_res_i, f_res_i} = dp_res;
      is_overflow_i  = dp_ovf;
      is_underflow_i = dp_udf;
      dp_valid = 1'b1;
      tick();
      dp_valid = 1'b0;
    end
  end

  // Model state: timestamps of the operation in flight, in cycle units.
  int           cyc = 0;
  bit           m_busy = 1'b0;
  bit           m_normal = 1'b0;
  int           m_rr = 0;
  int           m_id = 0;
  int           m_issue = 0;
  int           m_due = -1;
  logic [15:0]  m_op = '0;
  logic [15:0]  m_res = '0;
  logic [3:0]   m_fl = '0;
  int           grants_q[$];
  int           rsp_count = 0;

  always @(negedge clk) begin : cmp
    int g;
    logic [1:0]  exp_ready;
    bit          exp_dsq;
    bit          exp_opnd;
    bit          exp_rv;
    logic [15:0] sres;
    logic [3:0]  sfl;
    cyc++;
    if (rst) begin
      m_busy = 1'b0;
      m_rr   = 0;
      m_due  = -1;
    end else begin
      g = -1;
      for (int k = 0; k < N_REQ; k++)
        if (g < 0 && req_valid_i[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;
      exp_ready = (!m_busy && g >= 0) ? (2'b01 << g) : 2'b00;
      exp_dsq  = m_busy && m_normal && cyc == m_issue;
      exp_opnd = m_busy && m_normal && cyc >= m_issue && (m_due < 0 || cyc < m_due);
      exp_rv   = m_busy && m_due >= 0 && cyc >= m_due;
      check("req_ready", req_ready_o, exp_ready);
      check("do_sqrt", do_sqrt_o, exp_dsq);
      check("operand", {signum_op_o, ext_exp_op_o, ext_mant_op_o},
            exp_opnd ? {m_op[15], 1'b0, m_op[14:7], 1'b1, m_op[6:0]} : 18'h0);
      check("inf_zero_ties", {is_inf_op_o, is_zero_op_o}, 2'b00);
      check("rsp_valid", rsp_valid_o, exp_rv);
      if (exp_rv && rsp_valid_o === 1'b1) begin
        check("rsp_res", rsp_res_o, m_res);
        check("rsp_flags", rsp_flags_o, m_fl);
        check("rsp_id", rsp_id_o, m_id);
      end
      if (exp_rv && rsp_ready_i) begin
        m_busy = 1'b0;
        m_rr   = (m_id + 1) % N_REQ;
        m_due  = -1;
        rsp_count++;
      end else if (m_busy && m_normal && m_due < 0 && cyc > m_issue) begin
        if (valid_i) begin
          m_res = {s_res_i, e_res_i, f_res_i};
          m_fl  = {1'b0, is_overflow_i, is_underflow_i, 1'b0};
          m_due = cyc + 1;
        end else if (cyc == m_issue + TIMEOUT) begin
          m_res = 16'h7FC0;
          m_fl  = 4'b0001;
          m_due = cyc + 1;
        end
      end else if (!m_busy && g >= 0) begin
        m_busy = 1'b1;
        m_id   = g;
        m_op   = req_op_i[g*W +: W];
        grants_q.push_back(g);
        if (model_special(m_op, sres, sfl)) begin
          m_normal = 1'b0;
          m_res    = sres;
          m_fl     = sfl;
          m_due    = cyc + 1;
        end else begin
          m_normal = 1'b1;
          m_issue  = cyc + 1;
          m_due    = -1;
        end
      end
    end
  end

  logic [15:0] sp_op  [6] = '{16'hBF80, 16'h7F80, 16'h8000, 16'h0001, 16'h7FC1, 16'hFF80};
  logic [15:0] sp_res [6] = '{16'h7FC0, 16'h7F80, 16'h8000, 16'h0000, 16'h7FC0, 16'h7FC0};
  logic [3:0]  sp_fl  [6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int base_g;
    int base_r;
    int gv;
    bit mb;
    logic [15:0] mr;
    logic [3:0]  mf;
    req_valid_i = '0;
    req_op_i    = '0;
    rsp_ready_i = 1'b0;
    s_res_i = 1'b0; e_res_i = '0; f_res_i = '0;
    is_overflow_i = 1'b0; is_underflow_i = 1'b0;

    mb = model_special(16'hBF80, mr, mf);
    check("model_pin_neg", {mb, mr, mf}, {1'b1, 16'h7FC0, 4'b1000});
    mb = model_special(16'h4080, mr, mf);
    check("model_pin_normal", {31'h0, mb}, 32'h0);

    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", {rsp_valid_o, do_sqrt_o, req_ready_o, rsp_res_o, rsp_flags_o, ext_exp_op_o},
          32'h0);

    // Normal op 4.0 -> 2.0, datapath valid 3 cycles after doSqrt.
    dp_delay = 3; dp_res = 16'h4000;
    req_op_i[15:0] = 16'h4080; req_valid_i = 2'b01;
    tick();
    req_valid_i = '0;
    check("t1_do_sqrt", do_sqrt_o, 1);
    check("t1_operand", {signum_op_o, ext_exp_op_o, ext_mant_op_o}, {1'b0, 9'h081, 8'h80});
    lat = 1;
    while (rsp_valid_o !== 1'b1 && lat < 50) begin tick(); lat++; end
    check("t1_latency", lat, 5);
    check("t1_res", rsp_res_o, 16'h4000);
    check("t1_id_flags", {rsp_id_o, rsp_flags_o}, 5'h00);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;

    // Round-robin from a fresh reset with both requesters always valid.
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    dp_delay = 2; dp_res = 16'h4040; dp_udf = 1'b1;
    req_op_i = {16'h4110, 16'h4080};
    base_g = grants_q.size(); base_r = rsp_count;
    rsp_ready_i = 1'b1; req_valid_i = 2'b11;
    for (int i = 0; i < 400 && rsp_count < base_r + 4; i++) tick();
    req_valid_i = '0; rsp_ready_i = 1'b0; dp_udf = 1'b0;
    check("t2_ops_done", rsp_count - base_r, 4);
    for (int i = 0; i < 4; i++) begin
      gv = (grants_q.size() > base_g + i) ? grants_q[base_g + i] : -1;
      check("t2_grant_order", gv, i % 2);
    end

    // Special operands, answered one cycle after the handshake.
    for (int i = 0; i < 6; i++) begin
      req_op_i = {sp_op[i], sp_op[i]};
      req_valid_i = (i % 2 == 1) ? 2'b10 : 2'b01;
      tick();
      req_valid_i = '0;
      check("t3_valid", rsp_valid_o, 1);
      check("t3_res", rsp_res_o, sp_res[i]);
      check("t3_flags", rsp_flags_o, sp_fl[i]);
      check("t3_id", rsp_id_o, i % 2);
      check("t3_no_sqrt", do_sqrt_o, 0);
      rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    end

    // Datapath never answers.
    dp_delay = 0;
    req_op_i[15:0] = 16'h4080; req_valid_i = 2'b01;
    tick();
    req_valid_i = '0;
    lat = 1;
    while (rsp_valid_o !== 1'b1 && lat < 100) begin tick(); lat++; end
    check("t4_timeout_latency", lat, TIMEOUT + 2);
    check("t4_res", rsp_res_o, 16'h7FC0);
    check("t4_flags", rsp_flags_o, 4'b0001);
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    late_valid = 1'b1; tick(); late_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_late_valid_ignored", {rsp_valid_o, do_sqrt_o}, 2'b00);
    end

    // Back-pressure: pointer is now 1, both requesters valid.
    req_op_i = {16'h7F80, 16'h8000}; req_valid_i = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t5_hold", {rsp_valid_o, rsp_id_o, rsp_res_o, rsp_flags_o}, {1'b1, 1'b1, 16'h7F80, 4'h0});
      check("t5_no_grant", req_ready_o, 2'b00);
      tick();
    end
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;
    check("t5_next_grant", req_ready_o, 2'b01);
    tick();
    req_valid_i = '0;
    check("t5_second_res", {rsp_valid_o, rsp_id_o, rsp_res_o}, {1'b1, 1'b0, 16'h8000});
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;

    // Reset while waiting on the datapath (pointer is 1 before the reset).
    req_op_i[15:0] = 16'h4080; req_valid_i = 2'b01;
    tick();
    req_valid_i = '0;
    repeat (3) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_reset_outputs",
          {rsp_valid_o, do_sqrt_o, signum_op_o, ext_exp_op_o, ext_mant_op_o, rsp_flags_o, rsp_id_o}, 0);
    check("t6_reset_res", rsp_res_o, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_no_response", rsp_valid_o, 0);
    end
    dp_delay = 2; dp_res = 16'h4040;
    req_op_i = {16'h4110, 16'h4080}; req_valid_i = 2'b11;
    #1;
    check("t6_rr_reset", req_ready_o, 2'b01);
    tick();
    req_valid_i = '0;
    lat = 1;
    while (rsp_valid_o !== 1'b1 && lat < 50) begin tick(); lat++; end
    check("t6_latency", lat, 4);
    check("t6_rsp", {rsp_id_o, rsp_res_o, rsp_flags_o}, {1'b0, 16'h4040, 4'h0});
    rsp_ready_i = 1'b1; tick(); rsp_ready_i = 1'b0;

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
